// File: rtl/wisc_pkg.sv
// wisc_pkg: ALU opcodes, branch condition codes and FSM states shared by the flag/branch logic
package wisc_pkg;
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_RED    = 3'b011;
    localparam logic [2:0] OP_SLL    = 3'b100;
    localparam logic [2:0] OP_SRA    = 3'b101;
    localparam logic [2:0] OP_ROR    = 3'b110;
    localparam logic [2:0] OP_PADDSB = 3'b111;

    typedef enum logic [2:0] {
        CC_NE, CC_EQ, CC_GT, CC_LT, CC_GTE, CC_LTE, CC_OV, CC_UNCOND
    } ccc_t;

    typedef enum logic {IDLE, HOLD} fbu_state_t;

    function automatic logic writes_nv(input logic [2:0] opcode);
        return opcode == OP_ADD || opcode == OP_SUB;
    endfunction
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational condition-code check of {N,V,Z} flags
module branch_cond_eval
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] nvz,
    output logic       taken
);
    logic n, v, z;
    assign {n, v, z} = nvz;

    always_comb begin
        taken = 1'b1;
        case (ccc_t'(ccc))
            CC_NE:   taken = !z;
            CC_EQ:   taken = z;
            CC_GT:   taken = !z && !n;
            CC_LT:   taken = n;
            CC_GTE:  taken = z || !n;
            CC_LTE:  taken = n || z;
            CC_OV:   taken = v;
            default: taken = 1'b1;
        endcase
    end
endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: N/V/Z flag register plus branch resolution with a flag-hazard stall FSM.
// FLAG_BYPASS_EN: evaluate a colliding branch on merged ALU flags instead of stalling.
module flag_branch_unit
    import wisc_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [2:0]      alu_opcode,
    input  logic [2:0]      alu_nvz,
    input  logic            br_valid,
    input  logic [2:0]      br_ccc,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] br_pc_plus2,
    input  logic            flush,
    output logic            br_ready,
    output logic            stall,
    output logic            br_done,
    output logic            br_taken,
    output logic [PC_W-1:0] br_next_pc,
    output logic [2:0]      nvz_q
);
    fbu_state_t state, state_nx;
    logic       collide, taken;
    logic [2:0] nvz_merged, nvz_eval;

    // Non-arithmetic ops only own Z; N and V carry over from the register
    assign nvz_merged = writes_nv(alu_opcode) ? alu_nvz : {nvz_q[2:1], alu_nvz[0]};

`ifdef FLAG_BYPASS_EN
    assign collide  = 1'b0;
    assign nvz_eval = (state == IDLE && alu_valid) ? nvz_merged : nvz_q;
`else
    assign collide  = alu_valid;
    assign nvz_eval = nvz_q;
`endif

    always_comb begin
        stall    = state == IDLE && br_valid && !flush && collide;
        br_ready = !flush && (state == HOLD || (br_valid && !collide));
        state_nx = stall ? HOLD : IDLE;
    end

    branch_cond_eval u_eval (
        .ccc   (br_ccc),
        .nvz   (nvz_eval),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            nvz_q      <= 3'b000;
            br_done    <= 1'b0;
            br_taken   <= 1'b0;
            br_next_pc <= '0;
        end else begin
            state   <= state_nx;
            br_done <= br_ready;
            if (alu_valid)
                nvz_q <= nvz_merged;
            if (br_ready) begin
                br_taken   <= taken;
                br_next_pc <= taken ? br_target : br_pc_plus2;
            end
        end
    end
endmodule
